// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns a debounced button level into discrete gesture events:
//   short  (01) - one press released before LONG_CYCLES, then no second press
//                 within DCLICK_CYCLES of the release
//   long   (10) - press held for LONG_CYCLES; nothing more until release
//   double (11) - press, release, and a second press started within the
//                 double-click window, reported when the second press ends
//
// Events are offered on a valid/ready handshake. An event raised while an
// earlier one is still waiting is dropped and evt_overflow latches until rst.
//
// Optional feature (define BTN_EVT_CNT_EN): adds evt_count, an 8-bit wrapping
// count of accepted handshakes.
//
// Parameters
//   LONG_CYCLES    held cycles that qualify as a long press (>= 2)
//   DCLICK_CYCLES  max release-to-second-press gap for a double click (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   btn_level     debounced button level, 1 = pressed
//   evt_valid     event presented
//   evt_code      event kind (01 short, 10 long, 11 double)
//   evt_ready     consumer accepts when evt_valid & evt_ready at a rising edge
//   evt_overflow  sticky: an event was dropped
//   evt_count     (BTN_EVT_CNT_EN only) accepted-event count, wraps at 255
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned DCLICK_CYCLES = 15000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow
`ifdef BTN_EVT_CNT_EN
  ,
  output logic [7:0] evt_count
`endif
);

  // Counter wide enough for the larger of the two windows, plus one bit.
  localparam int unsigned CntMax = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] DclickLast = CntW'(DCLICK_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeShort  = 2'b01;
  localparam logic [1:0] CodeLong   = 2'b10;
  localparam logic [1:0] CodeDouble = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StLongHeld,
    StWait2,
    StPress2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // An event raised by a state transition is staged here for one cycle, so it
  // reaches the outputs on the cycle after the transition that produced it.
  logic       raise_q, raise_d;
  logic [1:0] raise_code_q, raise_code_d;

  logic       evt_valid_q, evt_valid_d;
  logic [1:0] evt_code_q, evt_code_d;
  logic       evt_overflow_q, evt_overflow_d;
  logic       accept;

  // ---------------------------------------------------------------------------
  // Gesture FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      raise_q      <= 1'b0;
      raise_code_q <= CodeNone;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      raise_q      <= raise_d;
      raise_code_q <= raise_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Gesture FSM: next state, counter and event raise
  // Each counting state leaves at its terminal count, so cnt never wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    raise_d      = 1'b0;
    raise_code_d = CodeNone;

    unique case (state_q)
      StIdle: begin
        if (btn_level) begin
          state_d = StPress1;
          cnt_d   = '0;
        end
      end

      StPress1: begin
        if (!btn_level) begin
          state_d = StWait2;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d      = StLongHeld;
          raise_d      = 1'b1;
          raise_code_d = CodeLong;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      // Long already reported; the rest of the hold is silent.
      StLongHeld: begin
        if (!btn_level) begin
          state_d = StIdle;
        end
      end

      StWait2: begin
        if (btn_level) begin
          state_d = StPress2;
        end else if (cnt_q == DclickLast) begin
          state_d      = StIdle;
          raise_d      = 1'b1;
          raise_code_d = CodeShort;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      // Second press of a double click: length is irrelevant, only release.
      StPress2: begin
        if (!btn_level) begin
          state_d      = StIdle;
          raise_d      = 1'b1;
          raise_code_d = CodeDouble;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event output register with valid/ready handshake
  // ---------------------------------------------------------------------------
  assign accept = evt_valid_q & evt_ready;

  always_comb begin
    evt_valid_d    = evt_valid_q;
    evt_code_d     = evt_code_q;
    evt_overflow_d = evt_overflow_q;

    if (raise_q) begin
      // The slot is free if empty or being emptied on this same edge, which
      // lets back-to-back events flow with no gap cycle.
      if (!evt_valid_q || accept) begin
        evt_valid_d = 1'b1;
        evt_code_d  = raise_code_q;
      end else begin
        evt_overflow_d = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q    <= 1'b0;
      evt_code_q     <= CodeNone;
      evt_overflow_q <= 1'b0;
    end else begin
      evt_valid_q    <= evt_valid_d;
      evt_code_q     <= evt_code_d;
      evt_overflow_q <= evt_overflow_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_code     = evt_code_q;
  assign evt_overflow = evt_overflow_q;

`ifdef BTN_EVT_CNT_EN
  // ---------------------------------------------------------------------------
  // Accepted-handshake counter, wraps naturally at 8 bits
  // ---------------------------------------------------------------------------
  logic [7:0] evt_count_q, evt_count_d;

  always_comb begin
    evt_count_d = evt_count_q;
    if (accept) begin
      evt_count_d = evt_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count_q <= 8'd0;
    end else begin
      evt_count_q <= evt_count_d;
    end
  end

  assign evt_count = evt_count_q;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// Bench for button_event_decoder with LONG_CYCLES=20, DCLICK_CYCLES=10.
// Directed scenarios check the documented response timings with fixed
// expectations; a randomized scenario runs a gesture model built on run
// lengths of the button level against the DUT every cycle.
// Define BTN_EVT_CNT_EN to also exercise evt_count.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int unsigned LongC   = 20;
  localparam int unsigned DclickC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_level;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;
`ifdef BTN_EVT_CNT_EN
  logic [7:0] evt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYCLES  (LongC),
    .DCLICK_CYCLES(DclickC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_level   (btn_level),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ready   (evt_ready),
    .evt_overflow(evt_overflow)
`ifdef BTN_EVT_CNT_EN
    ,
    .evt_count   (evt_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model, in terms of press/gap run lengths and a pending-event slot
  // ---------------------------------------------------------------------------
  bit         m_pressed;    // current run of samples is a press
  bit         m_long_done;  // this press already produced a long event
  int         m_clicks;     // completed short presses in the current gesture
  int         m_run;        // length of current press run
  int         m_gap;        // low samples since first release
  bit         m_pend;       // event raised on the latest edge
  logic [1:0] m_pend_code;
  bit         m_valid;
  logic [1:0] m_code;
  bit         m_ovf;
  int         m_count;

  function automatic void model_edge(input logic b, input logic r, input logic rdy);
    bit acc;
    if (r) begin
      m_pressed = 0; m_long_done = 0; m_clicks = 0; m_run = 0; m_gap = 0;
      m_pend = 0; m_pend_code = 2'b00;
      m_valid = 0; m_code = 2'b00; m_ovf = 0; m_count = 0;
      return;
    end
    // An event raised last edge is offered on this edge.
    acc = m_valid && rdy;
    if (acc) m_count = (m_count + 1) % 256;
    if (m_pend) begin
      if (!m_valid || acc) begin
        m_valid = 1;
        m_code  = m_pend_code;
      end else begin
        m_ovf = 1;
      end
    end else if (acc) begin
      m_valid = 0;
    end
    m_pend = 0;

    if (b) begin
      if (!m_pressed) begin
        m_pressed = 1;
        m_run     = 0;
      end
      m_run++;
      // Long needs LONG_CYCLES held samples after the one that starts the press.
      if (m_clicks == 0 && !m_long_done && m_run == int'(LongC) + 1) begin
        m_long_done = 1;
        m_pend = 1; m_pend_code = 2'b10;
      end
    end else begin
      if (m_pressed) begin
        m_pressed = 0;
        if (m_long_done) begin
          m_long_done = 0;
          m_clicks    = 0;
        end else if (m_clicks == 1) begin
          m_clicks = 0;
          m_pend = 1; m_pend_code = 2'b11;
        end else begin
          m_clicks = 1;
          m_gap    = 0;
        end
      end
      if (m_clicks == 1) begin
        m_gap++;
        if (m_gap == int'(DclickC) + 1) begin
          m_clicks = 0;
          m_pend = 1; m_pend_code = 2'b01;
        end
      end
    end
  endfunction

  // Drive one clock cycle; outputs are settled 1 time unit after the edge.
  task automatic cycle(input logic b, input logic r, input logic rdy);
    btn_level = b;
    rst       = r;
    evt_ready = rdy;
    @(posedge clk);
    model_edge(b, r, rdy);
    #1;
  endtask

  task automatic reset_idle();
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", evt_valid);
    end
    checks++;
    if (evt_code !== 2'b00) begin
      errors++; $display("FAIL reset_code got=%b want=00", evt_code);
    end
    checks++;
    if (evt_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got=%b want=0", evt_overflow);
    end
`ifdef BTN_EVT_CNT_EN
    checks++;
    if (evt_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got=%0d want=0", evt_count);
    end
`endif
  endtask

  task automatic test_short();
    logic exp_v;
    reset_idle();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      exp_v = (k == 11);
      checks++;
      if (evt_valid !== exp_v) begin
        errors++; $display("FAIL short_valid k=%0d got=%b want=%b", k, evt_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (evt_code !== 2'b01) begin
          errors++; $display("FAIL short_code got=%b want=01", evt_code);
        end
      end
    end
  endtask

  task automatic test_long();
    logic exp_v;
    int   seen;
    reset_idle();
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      cycle(1'b1, 1'b0, 1'b1);
      exp_v = (j == 21);
      if (evt_valid === 1'b1) seen++;
      checks++;
      if (evt_valid !== exp_v) begin
        errors++; $display("FAIL long_valid j=%0d got=%b want=%b", j, evt_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (evt_code !== 2'b10) begin
          errors++; $display("FAIL long_code got=%b want=10", evt_code);
        end
      end
    end
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (evt_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL long_event_count got=%0d want=1", seen);
    end
  endtask

  task automatic test_double();
    logic exp_v;
    reset_idle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      exp_v = (k == 1);
      checks++;
      if (evt_valid !== exp_v) begin
        errors++; $display("FAIL double_valid k=%0d got=%b want=%b", k, evt_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (evt_code !== 2'b11) begin
          errors++; $display("FAIL double_code got=%b want=11", evt_code);
        end
      end
    end
  endtask

  task automatic test_overflow();
    reset_idle();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b01 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first got v=%b c=%b o=%b want v=1 c=01 o=0",
               evt_valid, evt_code, evt_overflow);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b01 || evt_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_second got v=%b c=%b o=%b want v=1 c=01 o=1",
               evt_valid, evt_code, evt_overflow);
    end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_accept got v=%b o=%b want v=0 o=1", evt_valid, evt_overflow);
    end
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (evt_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got=%b want=0", evt_overflow);
    end
  endtask

  task automatic test_back_to_back();
    reset_idle();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0);
    // Short pending; a long press fires and is loaded on the accept edge.
    for (int j = 0; j < 21; j++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
        errors++;
        $display("FAIL b2b_hold j=%0d got v=%b c=%b want v=1 c=01", j, evt_valid, evt_code);
      end
    end
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b10 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load got v=%b c=%b o=%b want v=1 c=10 o=0",
               evt_valid, evt_code, evt_overflow);
    end
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drop got=%b want=0", evt_valid);
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    reset_idle();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      checks++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL mrst_pre i=%0d got=%b want=0", i, evt_valid);
      end
    end
    cycle(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 30; j++) begin
      cycle(1'b1, 1'b0, 1'b1);
      exp_v = (j == 21);
      checks++;
      if (evt_valid !== exp_v || (exp_v && evt_code !== 2'b10)) begin
        errors++;
        $display("FAIL mrst_post j=%0d got v=%b c=%b want v=%b c=10",
                 j, evt_valid, evt_code, exp_v);
      end
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic b, r, rdy;
    int   len;
    cycle(1'b0, 1'b1, 1'b1);
    b = 1'b0;
    for (int g = 0; g < 80; g++) begin
      b   = ~b;
      len = (g % 7 == 3) ? int'($urandom_range(18, 30)) : int'($urandom_range(1, 14));
      for (int c = 0; c < len; c++) begin
        r   = ($urandom_range(0, 299) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        cycle(b, r, rdy);
        checks++;
        if (evt_valid !== m_valid) begin
          errors++; $display("FAIL rnd_valid g=%0d got=%b want=%b", g, evt_valid, m_valid);
        end
        if (m_valid) begin
          checks++;
          if (evt_code !== m_code) begin
            errors++; $display("FAIL rnd_code g=%0d got=%b want=%b", g, evt_code, m_code);
          end
        end
        checks++;
        if (evt_overflow !== m_ovf) begin
          errors++; $display("FAIL rnd_ovf g=%0d got=%b want=%b", g, evt_overflow, m_ovf);
        end
`ifdef BTN_EVT_CNT_EN
        checks++;
        if (evt_count !== 8'(m_count)) begin
          errors++; $display("FAIL rnd_count g=%0d got=%0d want=%0d", g, evt_count, m_count);
        end
`endif
      end
    end
  endtask

`ifdef BTN_EVT_CNT_EN
  task automatic test_count_wrap();
    reset_idle();
    for (int e = 0; e < 257; e++) begin
      cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (evt_count !== 8'd1) begin
      errors++; $display("FAIL count_wrap got=%0d want=1", evt_count);
    end
  endtask
`endif

  initial begin
    btn_level = 1'b0;
    rst       = 1'b1;
    evt_ready = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef BTN_EVT_CNT_EN
    test_count_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50000000, meaning the number of held cycles that qualifies as a long press (minimum 2).
REQ-002 The block SHALL have parameter DCLICK_CYCLES, default 15000000, meaning the maximum gap cycles between release and second press for a double click (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port btn_level, input, 1 bit: already-debounced button level, 1 = pressed.
REQ-006 The block SHALL have port evt_valid, output, 1 bit: an event is presented.
REQ-007 The block SHALL have port evt_code, output, 2 bits: 01 = short, 10 = long, 11 = double, 00 = never presented while valid.
REQ-008 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the event when evt_valid and evt_ready are both 1 on a rising edge.
REQ-009 The block SHALL have port evt_overflow, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, PRESS1, LONG_HELD, WAIT2 and PRESS2, plus one hold counter sized $clog2(max(LONG_CYCLES, DCLICK_CYCLES))+1 bits.
REQ-011 IDLE SHALL go to PRESS1 with counter cleared when btn_level = 1.
REQ-012 PRESS1 SHALL behave as follows:
- btn_level = 0: go to WAIT2, counter cleared.
- otherwise, when the counter equals LONG_CYCLES-1: raise a long event and go to LONG_HELD.
- otherwise: increment the counter.
REQ-013 LONG_HELD SHALL go to IDLE when btn_level = 0, and SHALL raise no further event regardless of hold duration.
REQ-014 WAIT2 SHALL behave as follows:
- btn_level = 1: go to PRESS2.
- otherwise, when the counter equals DCLICK_CYCLES-1: raise a short event and go to IDLE.
- otherwise: increment the counter.
REQ-015 PRESS2 SHALL raise a double event and go to IDLE when btn_level = 0, with no long-press timing applied in PRESS2.
REQ-016 A raised event SHALL appear on evt_valid/evt_code on the clock cycle after the state transition that raised it.
REQ-017 evt_valid and evt_code SHALL hold stable until accepted, and evt_valid SHALL drop the cycle after acceptance unless a new event is loaded that same edge.
REQ-018 An event raised on the same edge as an acceptance SHALL be loaded with no loss and no gap cycle.
REQ-019 An event raised while an unaccepted event is pending SHALL be discarded, SHALL leave the pending event unchanged, and SHALL set evt_overflow until rst.
REQ-020 The counter SHALL never wrap, because each state exits at its terminal count.

Reset
REQ-021 When rst = 1 at a rising edge, the block SHALL force the state to IDLE, the counter to 0, evt_valid to 0, evt_code to 00 and evt_overflow to 0, with priority over every other input.
REQ-022 A reset asserted mid-press SHALL produce no event, and a button still held after rst deasserts SHALL be treated as a new press starting in IDLE.

Configuration
REQ-023 When BTN_EVT_CNT_EN is defined, the block SHALL add output evt_count (8 bits), reset to 0, incremented on each accepted handshake and wrapping from 255 to 0.
REQ-024 When BTN_EVT_CNT_EN is undefined, evt_count and its logic SHALL be absent, with all other behaviour identical.

Verification (bench parameters LONG_CYCLES=20, DCLICK_CYCLES=10, evt_ready=1 unless stated)
REQ-025 Stimulus: press for 5 cycles, release, then idle. Required response: evt_code=01 is valid for 1 cycle, 11 cycles after the release edge.
REQ-026 Stimulus: hold for 40 cycles. Required response: exactly one evt_code=10, 21 cycles after the press edge, and nothing on release.
REQ-027 Stimulus: press 3, release 4, press 3, release. Required response: a single evt_code=11 the cycle after the second release, and no short event.
REQ-028 Stimulus: evt_ready=0 and two short clicks 30 cycles apart. Required response: the first event (01) is held, evt_overflow=1 after the second, and evt_code remains 01 until ready.
REQ-029 Stimulus: rst pulsed at hold cycle 15, button held 30 more cycles. Required response: no event before reset, then a long event 21 cycles after rst deasserts.
REQ-030 Stimulus: with BTN_EVT_CNT_EN defined, 257 accepted events. Required response: evt_count=1.
